// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and width helpers for conv2d_sched
package conv_pkg;
  typedef enum logic [2:0] {IDLE, INIT, INIT2, MAC, DRAIN, WRITE, DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r < 1 ? 1 : r;
  endfunction
  function automatic int acc_w(input int dw, input int taps);
    return 2 * dw + clog2(taps);
  endfunction
endpackage

// File: rtl/conv_mac.sv
// conv_mac: signed multiply-accumulate with padding gate, clear and bias load
module conv_mac
  import conv_pkg::*;
#(
  parameter int dw = 8,
  parameter int aw = acc_w(8, 9)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 pad,
  input  logic                 ld,
  input  logic signed [dw-1:0] a,
  input  logic signed [dw-1:0] b,
  input  logic signed [dw-1:0] bias,
  output logic signed [dw-1:0] res
);
  logic signed [2*dw-1:0] prod;
  logic signed [aw-1:0] inc;
  logic signed [aw-1:0] acc;
  always_comb begin
    prod = en && !pad ? (2*dw)'(a) * (2*dw)'(b) : '0;
    inc = (aw)'(prod) + (ld ? (aw)'(bias) : '0);
    res = acc[dw-1:0];
  end
  always_ff @(posedge clk) acc <= rst || clr ? '0 : acc + inc;
endmodule

// File: rtl/conv2d_sched.sv
// conv2d_sched: one-MAC 2-D convolution scheduler; define CONV2D_BIAS_EN for per-channel bias ports
module conv2d_sched
  import conv_pkg::*;
#(
  parameter int in_channels = 1,
  parameter int out_channels = 1,
  parameter int kernel_rows = 3,
  parameter int kernel_cols = 3,
  parameter int stride_row = 1,
  parameter int stride_col = 1,
  parameter int pad_rows = 0,
  parameter int pad_cols = 0,
  parameter int rows = 27,
  parameter int cols = 27,
  parameter int data_size = 8,
  localparam int o_rows = (rows + 2*pad_rows - kernel_rows)/stride_row + 1,
  localparam int o_cols = (cols + 2*pad_cols - kernel_cols)/stride_col + 1,
  localparam int iaw = clog2(in_channels*rows*cols),
  localparam int kaw = clog2(out_channels*in_channels*kernel_rows*kernel_cols),
  localparam int oaw = clog2(out_channels*o_rows*o_cols),
  localparam int baw = clog2(out_channels)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [iaw-1:0]              in_addr,
  input  logic signed [data_size-1:0] in_data,
  output logic [kaw-1:0]              kern_addr,
  input  logic signed [data_size-1:0] kern_data,
`ifdef CONV2D_BIAS_EN
  input  logic signed [data_size-1:0] bias_data,
  output logic [baw-1:0]              bias_addr,
`endif
  output logic [oaw-1:0]              out_addr,
  output logic signed [data_size-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready
);
  localparam int taps = in_channels*kernel_rows*kernel_cols;
  localparam int aw = acc_w(data_size, taps);
  localparam int cow = baw;
  localparam int orw = clog2(o_rows);
  localparam int ocw = clog2(o_cols);
  localparam int ciw = clog2(in_channels);
  localparam int krw = clog2(kernel_rows);
  localparam int kcw = clog2(kernel_cols);
  state_t state, nxt;
  logic [cow-1:0] co;
  logic [orw-1:0] orow;
  logic [ocw-1:0] ocol;
  logic [ciw-1:0] ci;
  logic [krw-1:0] kr;
  logic [kcw-1:0] kc;
  logic signed [31:0] r, c;
  logic pad, pad_d, en_d, ld, hs;
  logic kc_last, kr_last, ci_last, tap_last, ocol_last, orow_last, co_last;
  logic signed [data_size-1:0] bias, res;
`ifdef CONV2D_BIAS_EN
  assign bias_addr = co;
  assign bias = bias_data;
  assign ld = state == MAC && kc == '0 && kr == '0 && ci == '0;
`else
  assign bias = '0;
  assign ld = 1'b0;
`endif
  always_comb begin
    kc_last = kc == kcw'(kernel_cols - 1);
    kr_last = kr == krw'(kernel_rows - 1);
    ci_last = ci == ciw'(in_channels - 1);
    tap_last = kc_last && kr_last && ci_last;
    ocol_last = ocol == ocw'(o_cols - 1);
    orow_last = orow == orw'(o_rows - 1);
    co_last = co == cow'(out_channels - 1);
    hs = state == WRITE && out_ready;
    r = 32'(orow)*stride_row + 32'(kr) - pad_rows;
    c = 32'(ocol)*stride_col + 32'(kc) - pad_cols;
    pad = r < 0 || r >= rows || c < 0 || c >= cols;
    in_addr = state == MAC && !pad ? iaw'(32'(ci)*rows*cols + r*cols + c) : '0;
    kern_addr = state == MAC ? kaw'(((32'(co)*in_channels + 32'(ci))*kernel_rows + 32'(kr))*kernel_cols + 32'(kc)) : '0;
    out_addr = oaw'(32'(co)*o_rows*o_cols + 32'(orow)*o_cols + 32'(ocol));
    out_data = res;
    out_valid = state == WRITE;
    busy = state != IDLE && state != DONE;
    done = state == DONE;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? INIT : IDLE;
`ifdef CONV2D_BIAS_EN
      INIT: nxt = INIT2;
      INIT2: nxt = MAC;
`else
      INIT: nxt = MAC;
`endif
      MAC: nxt = tap_last ? DRAIN : MAC;
      DRAIN: nxt = WRITE;
      WRITE: nxt = out_ready ? (co_last && orow_last && ocol_last ? DONE : INIT) : WRITE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    en_d <= !rst && state == MAC;
    pad_d <= !rst && pad;
  end
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      {co, orow, ocol, ci, kr, kc} <= '0;
    end else begin
      if (state == INIT) {ci, kr, kc} <= '0;
      if (state == MAC) begin
        kc <= kc_last ? '0 : kc + kcw'(1);
        if (kc_last) kr <= kr_last ? '0 : kr + krw'(1);
        if (kc_last && kr_last) ci <= ci_last ? '0 : ci + ciw'(1);
      end
      if (hs) begin
        ocol <= ocol_last ? '0 : ocol + ocw'(1);
        if (ocol_last) orow <= orow_last ? '0 : orow + orw'(1);
        if (ocol_last && orow_last) co <= co_last ? '0 : co + cow'(1);
      end
    end
  end
  conv_mac #(.dw(data_size), .aw(aw)) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(state == INIT),
    .en(en_d),
    .pad(pad_d),
    .ld(ld),
    .a(in_data),
    .b(kern_data),
    .bias(bias),
    .res(res)
  );
endmodule

// File: doc/conv2d_sched.md
# conv2d_sched

Sequential controller that computes a 2-D convolution layer one tap per cycle, reusing one multiply-accumulate unit instead of a fully unrolled combinational array. It walks every output pixel of every output channel, fetches input and kernel operands from external synchronous memories, inserts zero padding, accumulates the products, and hands each finished pixel to an output buffer over a valid/ready handshake. It sits between the layer's input/kernel RAMs and the next layer's input buffer, and is started once per layer by the network sequencer.

## Interface
- in_channels, 1, input feature channels
- out_channels, 1, output feature channels
- kernel_rows / kernel_cols, 3 / 3, kernel height / width
- stride_row / stride_col, 1 / 1, stride
- pad_rows / pad_cols, 0 / 0, zero rows/cols added on each side
- rows / cols, 27 / 27, input height / width
- data_size, 8, signed operand and result width
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run the layer; ignored unless IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last output is accepted
- in_addr  out  clog2(in_channels*rows*cols)  input RAM address
- in_data  in  data_size  input RAM data, 1-cycle read latency
- kern_addr  out  clog2(out_channels*in_channels*kernel_rows*kernel_cols)  kernel RAM address
- kern_data  in  data_size  kernel RAM data, 1-cycle latency
- out_addr  out  clog2(out_channels*OR*OC)  output address, co*OR*OC + orow*OC + ocol
- out_data  out  data_size  result pixel
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts

## Operation
- OR = (rows + 2*pad_rows - kernel_rows)/stride_row + 1; OC analogous. T = in_channels*kernel_rows*kernel_cols taps per pixel.
- Loop order, outer to inner: co, orow, ocol, ci, kr, kc. Cross-correlation, no kernel flip.
- Input coordinate r = orow*stride_row + kr - pad_rows, c = ocol*stride_col + kc - pad_cols; in_addr = ci*rows*cols + r*cols + c; kern_addr = ((co*in_channels + ci)*kernel_rows + kr)*kernel_cols + kc.
- r or c outside [0,rows)/[0,cols): padding tap; operand forced to 0 at the accumulator, in_addr driven 0.
- Accumulator signed, width 2*data_size + clog2(T); products signed data_size x data_size. out_data = acc[data_size-1:0] (truncation, no saturation).
- FSM: IDLE -> (start) INIT -> MAC -> DRAIN -> WRITE -> INIT (more pixels) or DONE -> IDLE.
  - INIT: acc cleared; tap counters zeroed.
  - MAC: T cycles, one address pair issued per cycle; product of previous cycle's data accumulated.
  - DRAIN: last product accumulated.
  - WRITE: out_valid high, out_data/out_addr stable until out_ready; advance on handshake.
  - DONE: done=1 for one cycle, busy=0.
- start during non-IDLE: ignored, no effect on counters.
- rst in any state: FSM to IDLE, all counters and acc cleared, in-flight pixel discarded.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_data=0, out_addr=0, in_addr=0, kern_addr=0.
- start sampled at cycle 0 -> INIT at cycle 1, first addresses at cycle 2.
- Per pixel: 1 INIT + T MAC + 1 DRAIN + ≥1 WRITE = T+3 cycles with out_ready held high.
- out_valid never drops without a handshake; no combinational path from out_ready to out_valid.
- done asserts the cycle after the final handshake; busy falls in the same cycle.

## Configuration
- CONV2D_BIAS_EN defined: extra port bias_data (in, data_size, signed) and bias_addr (out, clog2(out_channels)), 1-cycle latency; bias_addr = co is driven in INIT and acc loads sign-extended bias_data at the first MAC cycle alongside the first product. INIT lengthens to 2 cycles; per pixel T+4.
- Undefined: no bias ports; acc starts at 0.

## Structure
- Shared package conv_pkg: state enumeration, clog2 helper function, accumulator width function.
- One sub-module conv_mac: signed multiply, padding-zero gate, accumulate/clear; controller holds only FSM and counters.

## Test plan
- 3x3 input 1..9, 1x1 kernel 2, 1 channel -> out_data 2,4,...,18 at out_addr 0..8, done after 9th handshake.
- 3x3 all-ones input, 3x3 all-ones kernel, pad 1 -> corners 4, edges 6, centre 9.
- 5x5 ramp, 3x3 kernel, stride 2 -> 2x2 outputs matching a reference model; each pixel exactly T+3 cycles apart with ready high.
- out_ready low for 5 cycles in WRITE -> out_valid, out_data, out_addr held, no address activity.
- rst asserted mid-MAC -> next cycle all outputs at reset values; fresh start produces full correct layer.
- CONV2D_BIAS_EN with bias -3, 2 out channels -> each channel's results offset by -3; start pulsed while busy has no effect.
